// File: rtl/cp_frame_pkg.sv
// Shared types and helpers for the receive-side cyclic-prefix frame sequencer.
package cp_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  typedef logic [1:0] cp_mode_t;

  localparam int unsigned NFFT_DEFAULT = 2048;
  // Longest symbol (mode 0) for the default FFT size.
  localparam int unsigned SYMLEN_MAX = NFFT_DEFAULT + (NFFT_DEFAULT >> 2);

  // CP length for an 802.22 mode: NFFT/4, /8, /16, /32.
  function automatic int unsigned lcp_of(cp_mode_t mode, int unsigned nfft);
    return nfft >> (32'd2 + 32'(mode));
  endfunction

endpackage

// File: rtl/cp_frame_ctrl_cp_sym_counter.sv
// Sample/symbol position counters for one frame, with boundary and end-of-frame decode.
module cp_sym_counter #(
  parameter int unsigned CW     = 12,
  parameter int unsigned NSYM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  input  logic [CW-1:0]     symlen,
  input  logic [NSYM_W-1:0] nsym,
  output logic [NSYM_W-1:0] sym_cnt,
  output logic              sos,
  output logic              eos,
  output logic              last
);

  logic [CW-1:0]     samp_q;
  logic [NSYM_W-1:0] sym_q;

  assign sos     = (samp_q == '0);
  assign eos     = (samp_q == symlen - CW'(1));
  assign last    = eos && (sym_q == nsym - NSYM_W'(1));
  assign sym_cnt = sym_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      sym_q  <= '0;
    end else if (clr) begin
      samp_q <= '0;
      sym_q  <= '0;
    end else if (inc) begin
      if (eos) begin
        samp_q <= '0;
        sym_q  <= sym_q + NSYM_W'(1);
      end else begin
        samp_q <= samp_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cp_frame_ctrl.sv
// Frame sequencer ahead of CP removal: forwards NSYM*(NFFT+LCP) tagged samples per frame start.
module cp_frame_ctrl
  import cp_frame_pkg::*;
#(
  parameter int unsigned NFFT   = NFFT_DEFAULT,
  parameter int unsigned DW     = 32,
  parameter int unsigned NSYM_W = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [DW-1:0]           DAT_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  output logic                    ACK_O,
  output logic [DW-1:0]           DAT_O,
  output logic                    CYC_O,
  output logic                    STB_O,
  output logic                    WE_O,
  input  logic                    ACK_I,
  input  logic                    FRM_START_I,
  input  logic [1:0]              CP_MODE_I,
  input  logic [NSYM_W-1:0]       NSYM_I,
  output logic [$clog2(NFFT)-1:0] LCP_O,
  output logic                    SOS_O,
  output logic                    EOS_O,
  output logic [NSYM_W-1:0]       SYM_IDX_O,
  output logic                    DONE_O,
  output logic                    ERR_O
);

  localparam int unsigned LW = $clog2(NFFT);
  localparam int unsigned CW = LW + 1;

  state_e state_q, state_d;

  logic [LW-1:0]     lcp_q;
  logic [CW-1:0]     symlen_q;
  logic [NSYM_W-1:0] nsym_q;
  logic [DW-1:0]     dat_q;
  logic              stb_q, sos_q, eos_q, done_q, err_q;
  logic [NSYM_W-1:0] sym_idx_q;

  logic [LW-1:0]     lcp_new;
  logic              accept, start_ok, abort, done_d, err_d;
  logic [NSYM_W-1:0] sym_cnt;
  logic              cnt_sos, cnt_eos, cnt_last;

  assign lcp_new = LW'(lcp_of(CP_MODE_I, NFFT));

  cp_sym_counter #(
    .CW     (CW),
    .NSYM_W (NSYM_W)
  ) u_cnt (
    .clk     (CLK_I),
    .rst     (RST_I),
    .inc     (accept),
    .clr     (start_ok),
    .symlen  (symlen_q),
    .nsym    (nsym_q),
    .sym_cnt (sym_cnt),
    .sos     (cnt_sos),
    .eos     (cnt_eos),
    .last    (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    start_ok = 1'b0;
    abort    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (FRM_START_I) begin
          if (NSYM_I != '0) begin
            start_ok = 1'b1;
            state_d  = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (!CYC_I) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          accept = STB_I & WE_I & (~stb_q | ACK_I);
          if (accept && cnt_last) state_d = StDrain;
        end
        if (FRM_START_I) err_d = 1'b1;
      end
      StDrain: begin
        // Completion wins over a coincident overrun start.
        if (stb_q && ACK_I) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (FRM_START_I) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      lcp_q     <= '0;
      symlen_q  <= '0;
      nsym_q    <= '0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      sos_q     <= 1'b0;
      eos_q     <= 1'b0;
      sym_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (start_ok) begin
        lcp_q    <= lcp_new;
        symlen_q <= CW'(NFFT) + CW'(lcp_new);
        nsym_q   <= NSYM_I;
      end
      if (abort) begin
        stb_q <= 1'b0;
        sos_q <= 1'b0;
        eos_q <= 1'b0;
      end else if (accept) begin
        dat_q     <= DAT_I;
        stb_q     <= 1'b1;
        sos_q     <= cnt_sos;
        eos_q     <= cnt_eos;
        sym_idx_q <= sym_cnt;
      end else if (stb_q && ACK_I) begin
        stb_q <= 1'b0;
        sos_q <= 1'b0;
        eos_q <= 1'b0;
      end
    end
  end

  assign ACK_O     = accept;
  assign DAT_O     = dat_q;
  assign CYC_O     = (state_q != StIdle);
  assign STB_O     = stb_q;
  assign WE_O      = stb_q;
  assign LCP_O     = lcp_q;
  assign SOS_O     = sos_q;
  assign EOS_O     = eos_q;
  assign SYM_IDX_O = sym_idx_q;
  assign DONE_O    = done_q;
  assign ERR_O     = err_q;

endmodule

// File: tb/tb_cp_frame_ctrl.sv
// Directed-plus-random bench for cp_frame_ctrl against a frame-level reference model.
module tb_cp_frame_ctrl;
  import cp_frame_pkg::*;

  localparam int unsigned NFFT   = 2048;
  localparam int unsigned DW     = 32;
  localparam int unsigned NSYM_W = 8;
  localparam int unsigned LW     = 11;

  logic              clk = 1'b0;
  logic              RST_I;
  logic [DW-1:0]     DAT_I;
  logic              CYC_I, STB_I, WE_I, ACK_O;
  logic [DW-1:0]     DAT_O;
  logic              CYC_O, STB_O, WE_O, ACK_I, FRM_START_I;
  logic [1:0]        CP_MODE_I;
  logic [NSYM_W-1:0] NSYM_I;
  logic [LW-1:0]     LCP_O;
  logic              SOS_O, EOS_O;
  logic [NSYM_W-1:0] SYM_IDX_O;
  logic              DONE_O, ERR_O;

  cp_frame_ctrl #(
    .NFFT   (NFFT),
    .DW     (DW),
    .NSYM_W (NSYM_W)
  ) dut (
    .CLK_I       (clk),
    .RST_I       (RST_I),
    .DAT_I       (DAT_I),
    .CYC_I       (CYC_I),
    .STB_I       (STB_I),
    .WE_I        (WE_I),
    .ACK_O       (ACK_O),
    .DAT_O       (DAT_O),
    .CYC_O       (CYC_O),
    .STB_O       (STB_O),
    .WE_O        (WE_O),
    .ACK_I       (ACK_I),
    .FRM_START_I (FRM_START_I),
    .CP_MODE_I   (CP_MODE_I),
    .NSYM_I      (NSYM_I),
    .LCP_O       (LCP_O),
    .SOS_O       (SOS_O),
    .EOS_O       (EOS_O),
    .SYM_IDX_O   (SYM_IDX_O),
    .DONE_O      (DONE_O),
    .ERR_O       (ERR_O)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ack_mode: 0 always ready, 1 toggling (ramp data), 2 random ready with random STB_I gaps.
  task automatic run_frame(input int mode, input int nsym, input int ack_mode,
                           input int abort_after, input int overrun_at, input bit rst_drain);
    int lcp    = (NFFT / 4) >> mode;
    int symlen = NFFT + lcp;
    int n      = nsym * symlen;
    int budget = nsym * SYMLEN_MAX * 4 + 200;
    logic [DW-1:0] src[$];
    logic [DW-1:0] prev_dat = '0;
    int sent = 0, got = 0, cyc = 0, stalls = 0;
    bit done_exp = 0, err_exp = 0, prev_stall = 0, aborting = 0, ov_done = 0, ov_check = 0;
    bit ack_drv;

    for (int k = 0; k < n; k++) src.push_back((ack_mode == 1) ? DW'(k) : DW'($urandom()));

    @(negedge clk);
    FRM_START_I = 1'b1;
    CP_MODE_I   = 2'(mode);
    NSYM_I      = NSYM_W'(nsym);
    CYC_I       = 1'b1;
    WE_I        = 1'b1;
    @(negedge clk);
    FRM_START_I = 1'b0;
    chk("cyc_rise", CYC_O, 1'b1);
    chk("lcp_latch", LCP_O, 64'(lcp));

    while (1) begin
      if (cyc > budget) begin
        chk("timeout_cycles", cyc, budget);
        break;
      end
      chk("done", DONE_O, done_exp);
      chk("err", ERR_O, err_exp);
      if (done_exp) begin
        chk("cyc_fall", CYC_O, 1'b0);
        chk("stb_fall", STB_O, 1'b0);
        chk("lcp_end", LCP_O, 64'(lcp));
        break;
      end
      if (aborting) begin
        chk("abort_cyc", CYC_O, 1'b0);
        chk("abort_stb", STB_O, 1'b0);
        chk("abort_ack", ACK_O, 1'b0);
        CYC_I = 1'b1;
        break;
      end
      if (ov_check) begin
        chk("lcp_hold", LCP_O, 64'(lcp));
        ov_check = 0;
      end
      if (prev_stall) begin
        chk("hold_dat", DAT_O, prev_dat);
        chk("hold_stb", STB_O, 1'b1);
      end
      if (rst_drain && stalls >= 3) begin
        ACK_I = 1'b1;
        #2;
        RST_I = 1'b1;
        #1;
        chk("rst_cyc", CYC_O, 1'b0);
        chk("rst_stb", STB_O, 1'b0);
        chk("rst_we", WE_O, 1'b0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_tags", {SOS_O, EOS_O, SYM_IDX_O}, 0);
        chk("rst_lcp", LCP_O, 0);
        chk("rst_ack", ACK_O, 1'b0);
        chk("rst_done", DONE_O, 1'b0);
        @(negedge clk);
        RST_I = 1'b0;
        @(negedge clk);
        chk("post_rst_done", DONE_O, 1'b0);
        chk("post_rst_err", ERR_O, 1'b0);
        chk("post_rst_cyc", CYC_O, 1'b0);
        break;
      end

      err_exp = 0;
      case (ack_mode)
        0:       ack_drv = 1'b1;
        1:       ack_drv = (cyc % 2 == 0);
        default: ack_drv = 1'($urandom_range(0, 1));
      endcase
      if (rst_drain && sent >= n) ack_drv = 1'b0;
      ACK_I = ack_drv;
      DAT_I = (sent < n) ? src[sent] : DW'($urandom());
      STB_I = (sent < n && ack_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      CP_MODE_I = 2'($urandom());
      NSYM_I    = NSYM_W'($urandom());
      if (overrun_at >= 0 && !ov_done && sent == overrun_at) begin
        FRM_START_I = 1'b1;
        CP_MODE_I   = 2'(mode ^ 3);
        NSYM_I      = NSYM_W'(5);
        err_exp     = 1;
        ov_done     = 1;
        ov_check    = 1;
      end else begin
        FRM_START_I = 1'b0;
      end
      if (abort_after >= 0 && sent >= abort_after) begin
        CYC_I    = 1'b0;
        err_exp  = 1;
        aborting = 1;
      end

      // Downstream handshake at the coming edge: compare against the model stream.
      if (STB_O && ack_drv) begin
        if (got < n) begin
          chk("dat", DAT_O, src[got]);
          chk("sos", SOS_O, (got % symlen) == 0);
          chk("eos", EOS_O, (got % symlen) == symlen - 1);
          chk("sym_idx", SYM_IDX_O, 64'(got / symlen));
        end else begin
          chk("extra_sample", got, n - 1);
        end
        got++;
        if (got == n && !aborting) done_exp = 1;
      end
      if (rst_drain && sent >= n && STB_O) stalls++;
      prev_stall = STB_O && !ack_drv;
      prev_dat   = DAT_O;

      #1;
      if (sent >= n) chk("drain_ack", ACK_O, 1'b0);
      if (ACK_O) sent++;
      @(negedge clk);
      cyc++;
    end
    FRM_START_I = 1'b0;
    STB_I       = 1'b0;
    ACK_I       = 1'b0;
  endtask

  initial begin
    RST_I       = 1'b1;
    DAT_I       = '0;
    CYC_I       = 1'b0;
    STB_I       = 1'b0;
    WE_I        = 1'b0;
    ACK_I       = 1'b0;
    FRM_START_I = 1'b0;
    CP_MODE_I   = '0;
    NSYM_I      = '0;
    #1;
    chk("reset_cyc", CYC_O, 1'b0);
    chk("reset_stb", STB_O, 1'b0);
    chk("reset_done_err", {DONE_O, ERR_O}, 0);
    chk("reset_lcp", LCP_O, 0);
    @(negedge clk);
    @(negedge clk);
    RST_I = 1'b0;
    @(negedge clk);

    // Mode 0, two symbols, always-ready sink.
    run_frame(0, 2, 0, -1, -1, 0);
    // Mode 3, one symbol, toggling sink with ramp data.
    run_frame(3, 1, 1, -1, -1, 0);

    // Zero-symbol start is rejected.
    @(negedge clk);
    FRM_START_I = 1'b1;
    NSYM_I      = '0;
    CP_MODE_I   = 2'($urandom());
    CYC_I       = 1'b1;
    STB_I       = 1'b1;
    WE_I        = 1'b1;
    #1;
    chk("nsym0_ack", ACK_O, 1'b0);
    @(negedge clk);
    FRM_START_I = 1'b0;
    chk("nsym0_err", ERR_O, 1'b1);
    chk("nsym0_cyc", CYC_O, 1'b0);
    chk("nsym0_ack2", ACK_O, 1'b0);
    @(negedge clk);
    chk("nsym0_err_once", ERR_O, 1'b0);
    chk("nsym0_cyc2", CYC_O, 1'b0);
    STB_I = 1'b0;

    // Abort after 1000 samples, then a clean frame.
    run_frame(1, 2, 0, 1000, -1, 0);
    run_frame(1, 1, 2, -1, -1, 0);
    // Overrun start with a different mode mid-frame.
    run_frame(2, 1, 2, -1, 500, 0);
    // Asynchronous reset during a drain stall, then recovery.
    run_frame(3, 1, 2, -1, -1, 1);
    run_frame(int'($urandom_range(0, 3)), 1, 2, -1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
